// File: rtl/seven_segment_decoder.sv
// ============================================================================
// Module      : seven_segment_decoder
// Description : Sniffs a multiplexed, active-low 4-digit seven-segment bus,
//               waits for each {an,seg} pattern to be stable, and decodes the
//               lit segments back into per-digit hex values, decimal points,
//               validity flags, error pulses and frame-complete pulses.
//               Optional macro SEG_DECODER_TIMEOUT_EN adds per-digit
//               staleness timers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_decoder #(
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [3:0] an,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] dp,
    output logic [3:0] valid,
    output logic       err,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    // Returns {hit, value} for an active-low g..a pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] s);
        case (s)
            7'h40:   hex_decode = 5'h10;
            7'h79:   hex_decode = 5'h11;
            7'h24:   hex_decode = 5'h12;
            7'h30:   hex_decode = 5'h13;
            7'h19:   hex_decode = 5'h14;
            7'h12:   hex_decode = 5'h15;
            7'h02:   hex_decode = 5'h16;
            7'h78:   hex_decode = 5'h17;
            7'h00:   hex_decode = 5'h18;
            7'h10:   hex_decode = 5'h19;
            7'h08:   hex_decode = 5'h1A;
            7'h03:   hex_decode = 5'h1B;
            7'h27:   hex_decode = 5'h1C;
            7'h21:   hex_decode = 5'h1D;
            7'h06:   hex_decode = 5'h1E;
            7'h0E:   hex_decode = 5'h1F;
            default: hex_decode = 5'h00;
        endcase
    endfunction

    logic [7:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  an_s1_q, an_s2_q;
    logic [11:0] smp_q;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  d_q [4];
    logic [3:0]  dp_q, valid_q, seen_q;
    logic        err_q, fd_q;

    logic [11:0] cur;
    logic        change;
    logic [7:0]  cnt_d;
    logic        stable_hit, blank, onehot;
    logic [1:0]  idx;
    logic [3:0]  idx_bit;
    logic [4:0]  dec;
    logic        legal_cap, illegal_cap;
    logic [3:0]  expire;
    logic [3:0]  seen_d, valid_d;
    logic        fd_d;

    // Two-flop synchronizer; idle bus value is all segments/anodes off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= 8'hFF;
            seg_s2_q <= 8'hFF;
            an_s1_q  <= 4'hF;
            an_s2_q  <= 4'hF;
        end else begin
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
        end
    end

    // Pattern classification, stability detection and decode
    always_comb begin
        cur        = {an_s2_q, seg_s2_q};
        change     = (cur != smp_q);
        cnt_d      = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        stable_hit = (state_q == ST_SETTLE) && !change && (cnt_q == CNT_LAST);
        blank      = (an_s2_q == 4'hF);
        onehot     = 1'b1;
        idx        = 2'd0;
        case (an_s2_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
        idx_bit     = 4'b0001 << idx;
        dec         = hex_decode(seg_s2_q[6:0]);
        legal_cap   = stable_hit && onehot && dec[4];
        illegal_cap = stable_hit && !blank && !(onehot && dec[4]);
    end

    // Next valid/seen flags; a capture overrides a simultaneous expiry
    always_comb begin
        valid_d = valid_q & ~expire;
        seen_d  = seen_q & ~expire;
        fd_d    = 1'b0;
        if (legal_cap) begin
            valid_d = valid_d | idx_bit;
            if ((seen_d | idx_bit) == 4'hF) begin
                fd_d   = 1'b1;
                seen_d = idx_bit;
            end else begin
                seen_d = seen_d | idx_bit;
            end
        end else if (illegal_cap && onehot) begin
            valid_d = valid_d & ~idx_bit;
        end
    end

`ifdef SEG_DECODER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       hlegal_q;
    logic [1:0] hidx_q;
    logic [3:0] reload;

    // Remember which digit is being held so it can keep refreshing its timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hlegal_q <= 1'b0;
            hidx_q   <= 2'd0;
        end else if (stable_hit) begin
            hlegal_q <= legal_cap;
            hidx_q   <= idx;
        end
    end

    always_comb begin
        reload = 4'b0000;
        if (legal_cap)
            reload = idx_bit;
        else if ((state_q == ST_HELD) && hlegal_q && !change)
            reload = 4'b0001 << hidx_q;
    end

    generate
        for (genvar n = 0; n < 4; n++) begin : g_tmr
            logic [TW-1:0] tmr_q;
            // Clocks since last refresh, saturating at the timeout point
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    tmr_q <= '0;
                else if (reload[n])
                    tmr_q <= '0;
                else if (tmr_q != TMO_LAST)
                    tmr_q <= tmr_q + 1'b1;
            end
            assign expire[n] = (tmr_q == TMO_LAST) && !reload[n];
        end
    endgenerate
`else
    assign expire = 4'b0000;
`endif

    // FSM plus registered capture outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q   <= 12'hFFF;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            for (int i = 0; i < 4; i++) d_q[i] <= 4'd0;
            dp_q    <= 4'b0000;
            valid_q <= 4'b0000;
            seen_q  <= 4'b0000;
            err_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            smp_q   <= cur;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            fd_q    <= fd_d;
            err_q   <= illegal_cap;
            if (change) begin
                state_q <= ST_SETTLE;
                cnt_q   <= 8'd1;
            end else begin
                cnt_q <= cnt_d;
                if (stable_hit)
                    state_q <= blank ? ST_IDLE : ST_HELD;
            end
            if (legal_cap) begin
                d_q[idx]  <= dec[3:0];
                dp_q[idx] <= ~seg_s2_q[7];
            end
        end
    end

    assign d0         = d_q[0];
    assign d1         = d_q[1];
    assign d2         = d_q[2];
    assign d3         = d_q[3];
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign frame_done = fd_q;

endmodule

`default_nettype wire
